ysyx_23060025_icache: RTL

// - Instruction-cache responder at the fetch-side request interface: accepts the fetch unit's paddr/psel

---
 rtl/ysyx_23060025_icache_pkg.sv | 16 +
 rtl/ysyx_23060025_icache_array.sv | 53 +++++
 rtl/ysyx_23060025_icache.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/ysyx_23060025_icache_pkg.sv
// Shared encodings for the instruction cache: FSM states and the fixed AXI4 read-burst fields.
package ysyx_23060025_icache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_MISS_AR,
        S_MISS_R,
        S_RESP
    } state_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ysyx_23060025_icache_array.sv
// Direct-mapped line storage: combinational read by set/word, single-cycle word, tag+valid and
// global-invalidate writes. Only the valid bits are reset; tag/data are qualified by them.
module ysyx_23060025_icache_array #(
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4,
    parameter int TAG_W      = 24,
    parameter int DATA_W     = 32,
    localparam int IDX_W     = $clog2(SETS),
    localparam int WRD_W     = $clog2(LINE_WORDS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [IDX_W-1:0]  rd_idx_i,
    input  logic [WRD_W-1:0]  rd_word_i,
    output logic              rd_valid_o,
    output logic [TAG_W-1:0]  rd_tag_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic              wr_word_en_i,
    input  logic [WRD_W-1:0]  wr_word_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              wr_tag_en_i,
    input  logic [TAG_W-1:0]  wr_tag_i,
    input  logic              wr_valid_i,
    input  logic              clr_all_i
);

    logic [SETS-1:0]   valid_q;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS][LINE_WORDS];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i][rd_word_i];

    always_ff @(posedge clock) begin
        if (reset || clr_all_i) begin
            valid_q <= '0;
        end else if (wr_tag_en_i) begin
            valid_q[wr_idx_i] <= wr_valid_i;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_tag_en_i) begin
            tag_q[wr_idx_i] <= wr_tag_i;
        end
        if (wr_word_en_i) begin
            data_q[wr_idx_i][wr_word_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ysyx_23060025_icache.sv
// Read-only direct-mapped instruction cache: fetch-side psel/pready responder with whole-line
// AXI4 INCR refills and fence.i invalidation.
module ysyx_23060025_icache
    import ysyx_23060025_icache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_psel,
    input  logic [ADDR_WIDTH-1:0] in_paddr,
    output logic                  in_pready,
    output logic [DATA_WIDTH-1:0] in_prdata,
    input  logic                  fencei_i,
    output logic                  acc_err_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic [7:0]            arlen_o,
    output logic [2:0]            arsize_o,
    output logic [1:0]            arburst_o,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rlast_i
);

    localparam int OFF = $clog2(LINE_WORDS) + 2;
    localparam int IDX = $clog2(SETS);
    localparam int TAG = ADDR_WIDTH - IDX - OFF;
    localparam int WRD = $clog2(LINE_WORDS);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:2] req_addr_q;
    logic [WRD-1:0]        beat_q;
    logic                  err_q, err_d;
    logic                  fence_pend_q;
    logic [DATA_WIDTH-1:0] resp_data_q, prdata_q;

    logic [TAG-1:0]        req_tag, rd_tag;
    logic [IDX-1:0]        req_idx;
    logic [WRD-1:0]        req_word;
    logic                  rd_valid, hit, beat_fire, clr_all;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  unused_paddr;

    assign unused_paddr = ^in_paddr[1:0];

    assign req_tag   = req_addr_q[ADDR_WIDTH-1:OFF];
    assign req_idx   = req_addr_q[OFF+IDX-1:OFF];
    assign req_word  = req_addr_q[OFF-1:2];
    assign hit       = rd_valid && (rd_tag == req_tag);
    assign beat_fire = (state_q == S_MISS_R) && rvalid_i;

    // A premature or missing rlast is folded into the same error as a bad rresp.
    assign err_d = err_q || (rresp_i != AXI_RESP_OKAY) ||
                   (rlast_i != (beat_q == WRD'(LINE_WORDS - 1)));

    ysyx_23060025_icache_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG),
        .DATA_W     (DATA_WIDTH)
    ) u_array (
        .clock        (clock),
        .reset        (reset),
        .rd_idx_i     (req_idx),
        .rd_word_i    (req_word),
        .rd_valid_o   (rd_valid),
        .rd_tag_o     (rd_tag),
        .rd_data_o    (rd_data),
        .wr_idx_i     (req_idx),
        .wr_word_en_i (beat_fire),
        .wr_word_i    (beat_q),
        .wr_data_i    (rdata_i),
        .wr_tag_en_i  (beat_fire && rlast_i),
        .wr_tag_i     (req_tag),
        .wr_valid_i   (!err_d && !fence_pend_q && !fencei_i),
        .clr_all_i    (clr_all)
    );

    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (in_psel) state_d = S_LOOKUP;
            S_LOOKUP:  state_d = hit ? S_IDLE : S_MISS_AR;
            S_MISS_AR: if (arready_i) state_d = S_MISS_R;
            S_MISS_R:  if (rvalid_i && rlast_i) state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_pready = 1'b0;
        acc_err_o = 1'b0;
        arvalid_o = 1'b0;
        rready_o  = 1'b0;
        clr_all   = 1'b0;
        case (state_q)
            S_IDLE:    clr_all   = fencei_i || fence_pend_q;
            S_LOOKUP:  in_pready = hit;
            S_MISS_AR: arvalid_o = 1'b1;
            S_MISS_R:  rready_o  = 1'b1;
            S_RESP: begin
                in_pready = 1'b1;
                acc_err_o = err_q;
            end
            default: ;
        endcase
    end

    assign in_prdata = !in_pready           ? prdata_q    :
                       (state_q == S_RESP)  ? resp_data_q : rd_data;
    assign araddr_o  = {req_addr_q[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
    assign arlen_o   = 8'(LINE_WORDS - 1);
    assign arsize_o  = AXI_SIZE_4B;
    assign arburst_o = AXI_BURST_INCR;

    always_ff @(posedge clock) begin
        if (reset) begin
            req_addr_q   <= '0;
            beat_q       <= '0;
            err_q        <= 1'b0;
            fence_pend_q <= 1'b0;
            resp_data_q  <= '0;
            prdata_q     <= '0;
        end else begin
            if (state_q == S_IDLE && in_psel) req_addr_q <= in_paddr[ADDR_WIDTH-1:2];
            // Fences seen while busy are held until the FSM is back in IDLE.
            fence_pend_q <= (state_q != S_IDLE) && (fence_pend_q || fencei_i);
            if (in_pready) prdata_q <= in_prdata;
            if (state_q == S_LOOKUP) begin
                beat_q <= '0;
                err_q  <= 1'b0;
            end
            if (beat_fire) begin
                beat_q <= beat_q + 1'b1;
                err_q  <= err_d;
                if (beat_q == req_word) resp_data_q <= rdata_i;
            end
        end
    end

endmodule
